// File: rtl/cpu_pkg.sv
// Shared types and constants for the 8-bit pipeline.
// Holds width constants, the register index type and the writeback source decode.
package cpu_pkg;

  localparam int DATA_W = 8;
  localparam int NREGS  = 4;
  localparam int IDX_W  = 2;

  typedef logic [IDX_W-1:0] reg_idx_t;

  typedef enum logic [1:0] {
    WB_ALU,
    WB_DM,
    WB_IN
  } wb_src_e;

  // The input port select dominates the data select.
  function automatic wb_src_e wb_src_decode(
    input logic wb_sel,
    input logic data_sel
  );
    if (wb_sel) return WB_IN;
    return data_sel ? WB_DM : WB_ALU;
  endfunction

endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB writeback bundle plus decode-stage read ports.
// master drives sources/indices; slave returns rd1/rd2/wb_value.
interface wb_regfile_if #(
  parameter int DATA_W = 8
);
  import cpu_pkg::*;

  logic [DATA_W-1:0] dm;
  logic [DATA_W-1:0] alu_ea;
  logic [DATA_W-1:0] in_port;
  reg_idx_t          ra;
  logic              wb_wb_sel;
  logic              wb_data_sel;
  logic              wb_reg_en;
  reg_idx_t          rs1;
  reg_idx_t          rs2;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic [DATA_W-1:0] wb_value;

  modport master (
    output dm, alu_ea, in_port, ra,
    output wb_wb_sel, wb_data_sel, wb_reg_en,
    output rs1, rs2,
    input  rd1, rd2, wb_value
  );

  modport slave (
    input  dm, alu_ea, in_port, ra,
    input  wb_wb_sel, wb_data_sel, wb_reg_en,
    input  rs1, rs2,
    output rd1, rd2, wb_value
  );

endinterface

// File: rtl/regfile_4x8.sv
// Architectural register storage: async active-low clear, 1 write, 2 raw reads.
// Ports: clk, rst, we/waddr/wdata, raddr1/raddr2 -> rdata1/rdata2.
module regfile_4x8
  import cpu_pkg::*;
#(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int NREGS  = cpu_pkg::NREGS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  reg_idx_t          waddr,
  input  logic [DATA_W-1:0] wdata,
  input  reg_idx_t          raddr1,
  input  reg_idx_t          raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = regs[raddr1];
  assign rdata2 = regs[raddr2];

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: source mux, bypassed register reads, retire counter, last-write record.
// Ports: clk, rst (async active-low), bus (slave), retire_cnt, last_ra, last_val.
module wb_regfile
  import cpu_pkg::*;
#(
  parameter int DATA_W  = cpu_pkg::DATA_W,
  parameter int NREGS   = cpu_pkg::NREGS,
  parameter int CNT_W   = 16,
  parameter int R0_ZERO = 0
) (
  input  logic              clk,
  input  logic              rst,
  wb_regfile_if.slave       bus,
  output logic [CNT_W-1:0]  retire_cnt,
  output reg_idx_t          last_ra,
  output logic [DATA_W-1:0] last_val
);

  localparam bit R0Z = (R0_ZERO != 0);

  wb_src_e           src;
  logic [DATA_W-1:0] wb_value;
  logic [DATA_W-1:0] raw1;
  logic [DATA_W-1:0] raw2;
  logic              we;
  logic              hit1;
  logic              hit2;
  logic              z1;
  logic              z2;

  assign src = wb_src_decode(bus.wb_wb_sel, bus.wb_data_sel);

  always_comb begin
    wb_value = bus.alu_ea;
    unique case (src)
      WB_IN:   wb_value = bus.in_port;
      WB_DM:   wb_value = bus.dm;
      default: wb_value = bus.alu_ea;
    endcase
  end

  assign bus.wb_value = wb_value;

  // r0 writes are dropped in storage only; they still retire.
  assign we = bus.wb_reg_en && !(R0Z && bus.ra == '0);

  regfile_4x8 #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_rf (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .waddr  (bus.ra),
    .wdata  (wb_value),
    .raddr1 (bus.rs1),
    .raddr2 (bus.rs2),
    .rdata1 (raw1),
    .rdata2 (raw2)
  );

  assign z1   = R0Z && bus.rs1 == '0;
  assign z2   = R0Z && bus.rs2 == '0;
  assign hit1 = bus.wb_reg_en && bus.ra == bus.rs1;
  assign hit2 = bus.wb_reg_en && bus.ra == bus.rs2;

  // Zero-register check outranks the bypass.
  assign bus.rd1 = z1 ? '0 : hit1 ? wb_value : raw1;
  assign bus.rd2 = z2 ? '0 : hit2 ? wb_value : raw2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retire_cnt <= '0;
      last_ra    <= '0;
      last_val   <= '0;
    end else if (bus.wb_reg_en) begin
      if (retire_cnt != '1)
        retire_cnt <= retire_cnt + 1'b1;
      last_ra  <= bus.ra;
      last_val <= wb_value;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: two instances (R0_ZERO=0/CNT_W=16, R0_ZERO=1/CNT_W=4).
// Both see identical stimulus; expectations are hand-computed.
module tb_wb_regfile;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] dm, alu_ea, in_port;
  reg_idx_t   ra, rs1, rs2;
  logic       wsel, dsel, en;

  wb_regfile_if #(.DATA_W(8)) bus0 ();
  wb_regfile_if #(.DATA_W(8)) bus1 ();

  assign bus0.dm = dm;          assign bus1.dm = dm;
  assign bus0.alu_ea = alu_ea;  assign bus1.alu_ea = alu_ea;
  assign bus0.in_port = in_port; assign bus1.in_port = in_port;
  assign bus0.ra = ra;          assign bus1.ra = ra;
  assign bus0.rs1 = rs1;        assign bus1.rs1 = rs1;
  assign bus0.rs2 = rs2;        assign bus1.rs2 = rs2;
  assign bus0.wb_wb_sel = wsel; assign bus1.wb_wb_sel = wsel;
  assign bus0.wb_data_sel = dsel; assign bus1.wb_data_sel = dsel;
  assign bus0.wb_reg_en = en;   assign bus1.wb_reg_en = en;

  logic [15:0] cnt0;
  logic [3:0]  cnt1;
  reg_idx_t    lra0, lra1;
  logic [7:0]  lval0, lval1;

  wb_regfile #(.CNT_W(16), .R0_ZERO(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0),
    .retire_cnt(cnt0), .last_ra(lra0), .last_val(lval0)
  );

  wb_regfile #(.CNT_W(4), .R0_ZERO(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1),
    .retire_cnt(cnt1), .last_ra(lra1), .last_val(lval1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    dm = 8'h00; alu_ea = 8'h00; in_port = 8'h00;
    ra = 2'd0; rs1 = 2'd0; rs2 = 2'd0;
    wsel = 1'b0; dsel = 1'b0; en = 1'b0;

    // Power-on reset values
    #2;
    check("rst_cnt0", 32'(cnt0), 32'd0);
    check("rst_cnt1", 32'(cnt1), 32'd0);
    check("rst_lval0", 32'(lval0), 32'd0);
    check("rst_rd1", 32'(bus0.rd1), 32'd0);
    tick();
    rst = 1'b1;
    tick();

    // Source mux sweep into r2
    dm = 8'hA5; alu_ea = 8'h3C; in_port = 8'h7E;
    ra = 2'd2; rs1 = 2'd2; rs2 = 2'd2;
    wsel = 1'b0; dsel = 1'b0; en = 1'b1;
    #1 check("mux00_wbv", 32'(bus0.wb_value), 32'h3C);
    tick(); en = 1'b0;
    #1 check("mux00_r2", 32'(bus0.rd1), 32'h3C);
    check("mux00_cnt", 32'(cnt0), 32'd1);

    dsel = 1'b1; en = 1'b1;
    #1 check("mux01_wbv", 32'(bus0.wb_value), 32'hA5);
    tick(); en = 1'b0;
    #1 check("mux01_r2", 32'(bus0.rd2), 32'hA5);
    check("mux01_cnt", 32'(cnt0), 32'd2);

    wsel = 1'b1; dsel = 1'b0; en = 1'b1;
    tick(); en = 1'b0;
    #1 check("mux10_r2", 32'(bus0.rd1), 32'h7E);
    check("mux10_cnt", 32'(cnt0), 32'd3);

    in_port = 8'h7F; dsel = 1'b1; en = 1'b1;
    tick(); en = 1'b0;
    #1 check("mux11_r2", 32'(bus1.rd1), 32'h7F);
    check("mux11_cnt1", 32'(cnt1), 32'd4);

    // Bypass on r1
    wsel = 1'b0; dsel = 1'b0;
    alu_ea = 8'h11; ra = 2'd1; en = 1'b1;
    tick();
    alu_ea = 8'h99; en = 1'b0; rs1 = 2'd1; rs2 = 2'd1;
    #1 check("byp_off_rd1", 32'(bus0.rd1), 32'h11);
    check("byp_off_rd2", 32'(bus0.rd2), 32'h11);
    en = 1'b1;
    #1 check("byp_on_rd1", 32'(bus0.rd1), 32'h99);
    check("byp_on_rd2", 32'(bus0.rd2), 32'h99);
    tick(); en = 1'b0;
    #1 check("byp_st_rd1", 32'(bus0.rd1), 32'h99);
    check("byp_cnt", 32'(cnt0), 32'd6);

    // Register 0 behaviour
    alu_ea = 8'hFF; ra = 2'd0; rs1 = 2'd0; rs2 = 2'd0; en = 1'b1;
    #1 check("r0z_pre_rd1", 32'(bus1.rd1), 32'h00);
    check("r0n_pre_rd1", 32'(bus0.rd1), 32'hFF);
    tick(); en = 1'b0;
    #1 check("r0z_rd1", 32'(bus1.rd1), 32'h00);
    check("r0z_lval", 32'(lval1), 32'hFF);
    check("r0z_lra", 32'(lra1), 32'd0);
    check("r0z_cnt", 32'(cnt1), 32'd7);
    check("r0n_rd1", 32'(bus0.rd1), 32'hFF);

    // Saturation of the 4-bit counter
    ra = 2'd3; en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      alu_ea = 8'(i);
      tick();
      if (i == 7) check("sat_reach", 32'(cnt1), 32'd15);
    end
    en = 1'b0; rs1 = 2'd3;
    #1 check("sat_hold", 32'(cnt1), 32'd15);
    check("cnt16", 32'(cnt0), 32'd27);
    check("sat_lval", 32'(lval0), 32'h13);
    check("sat_r3", 32'(bus0.rd1), 32'h13);

    // Reset on a commit edge
    alu_ea = 8'h55; ra = 2'd3; en = 1'b1;
    @(posedge clk);
    rst = 1'b0;
    #2 en = 1'b0;
    #1 check("rstw_r3", 32'(bus0.rd1), 32'h00);
    check("rstw_cnt", 32'(cnt0), 32'd0);
    check("rstw_lval", 32'(lval0), 32'h00);
    tick();
    rst = 1'b1;
    alu_ea = 8'h66; en = 1'b1;
    #1 check("post_pre_lval", 32'(lval0), 32'h00);
    tick(); en = 1'b0;
    #1 check("post_r3", 32'(bus0.rd1), 32'h66);
    check("post_lval", 32'(lval0), 32'h66);
    check("post_cnt", 32'(cnt0), 32'd1);

    // Mid-cycle reset with live register contents
    alu_ea = 8'h5A; ra = 2'd1; en = 1'b1;
    tick(); en = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("mid_cnt0", 32'(cnt0), 32'd0);
    check("mid_cnt1", 32'(cnt1), 32'd0);
    for (int i = 0; i < 4; i++) begin
      rs1 = reg_idx_t'(i); rs2 = reg_idx_t'(i);
      #1;
      check("mid_rd1", 32'(bus0.rd1), 32'h00);
      check("mid_rd2", 32'(bus0.rd2), 32'h00);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
